// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared types and constants for the 7-segment chain driver:
//            FSM state type, frame width, digit count and the hex segment LUT.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Frame sequencing states of the chain driver.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH    = 3'd3,
    DONE     = 3'd4
  } seg7_state_t;

  // 8 digits x 8 bits per digit.
  localparam int SEG7_FRAME_W = 64;
  localparam int SEG7_DIGITS  = 8;

  // Segment byte layout is {dp,g,f,e,d,c,b,a}, active-high; bit 7 of every
  // entry is zero so the decimal point can be OR-ed in afterwards.
  localparam logic [7:0] SEG7_HEX_LUT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_hex_decoder
// Purpose  : Combinational nibble + decimal point -> 7-segment byte.
//            A blanked digit shows no segments but keeps its decimal point.
// Ports    : i_nibble [3:0] hex digit value
//            i_dp           decimal point for this digit
//            i_blank        suppress segments a..g
//            o_seg    [7:0] {dp,g,f,e,d,c,b,a}, active-high
// Revision : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  logic [7:0] w_pattern;

  assign w_pattern = SEG7_HEX_LUT[i_nibble];

  // LUT bit 7 is always zero, so OR-ing in the dp bit is a pure insert.
  assign o_seg = i_blank ? {i_dp, 7'h00} : (w_pattern | {i_dp, 7'h00});

endmodule : seg7_hex_decoder
`default_nettype wire

// File: rtl/seg7_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_chain_driver
// Purpose  : Decodes a 32-bit value plus decimal-point mask into eight
//            7-segment bytes and shifts the resulting 64-bit frame, MSB
//            first, into a daisy-chained 74HC595 string using SPI mode 0
//            timing derived from clk_i, then pulses the storage latch.
// Params   : CLK_DIV    half-period of sr_sclk_o in clk_i cycles (1..255)
//            NUM_DIGITS digits in the chain, must be 8
// Macro    : SEG7_LZ_BLANK_EN - when defined, digits above the most
//            significant nonzero nibble are blanked (dp still shown);
//            digit 0 is always displayed.
// Ports    : clk_i        system clock
//            rst_ni       asynchronous active-low reset
//            start_i      frame request, sampled only while idle
//            data_i[31:0] value, nibble k drives digit k
//            dp_i[7:0]    decimal points, bit k drives digit k
//            busy_o       frame in progress
//            done_o       one-cycle completion pulse
//            sr_sclk_o    shift clock (SHCP), idles low
//            sr_data_o    serial data (DS)
//            sr_latch_o   storage clock (STCP)
//            sr_oe_no     output enable, active-low; released after first frame
// Revision : 1.0 - initial release
// ============================================================================
module seg7_chain_driver
  import seg7_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int NUM_DIGITS = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  dp_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        sr_sclk_o,
  output logic        sr_data_o,
  output logic        sr_latch_o,
  output logic        sr_oe_no
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (NUM_DIGITS != SEG7_DIGITS) begin : g_bad_num_digits
      $error("seg7_chain_driver: NUM_DIGITS must be 8");
    end
    if ((CLK_DIV < 1) || (CLK_DIV > 255)) begin : g_bad_clk_div
      $error("seg7_chain_driver: CLK_DIV must be in 1..255");
    end
  endgenerate

  localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);
  localparam logic [5:0] c_bit_last = 6'd63;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  seg7_state_t              r_state;
  seg7_state_t              w_state_nxt;
  logic [7:0]               r_div_cnt;
  logic [5:0]               r_bit_cnt;
  logic [SEG7_FRAME_W-1:0]  r_frame;
  logic [SEG7_FRAME_W-1:0]  w_frame_nxt;
  logic [SEG7_FRAME_W-1:0]  w_frame_dec;
  logic [SEG7_DIGITS-1:0]   w_blank;
  logic                     w_div_last;
  logic                     w_timed;
  logic                     w_load;
  logic                     w_shift;

  logic                     r_busy;
  logic                     r_done;
  logic                     r_sclk;
  logic                     r_sdata;
  logic                     r_latch;
  logic                     r_oe_n;

  // --------------------------------------------------------------------------
  // Digit decode: digit k occupies frame bits [8k+7:8k], so digit 7 sits
  // at the MSB end and leaves the chain first.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < SEG7_DIGITS; k++) begin : g_digit
`ifdef SEG7_LZ_BLANK_EN
      if (k == 0) begin : g_lsd
        assign w_blank[k] = 1'b0;
      end else begin : g_upper
        // Blank when this nibble and every nibble above it are zero.
        assign w_blank[k] = (data_i[31:4*k] == '0);
      end
`else
      assign w_blank[k] = 1'b0;
`endif
      seg7_hex_decoder u_dec (
        .i_nibble (data_i[4*k +: 4]),
        .i_dp     (dp_i[k]),
        .i_blank  (w_blank[k]),
        .o_seg    (w_frame_dec[8*k +: 8])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and datapath strobes
  // --------------------------------------------------------------------------
  assign w_div_last = (r_div_cnt == c_div_last);
  assign w_timed    = (r_state == SHIFT_LO) || (r_state == SHIFT_HI) ||
                      (r_state == LATCH);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = SHIFT_LO;
          w_load      = 1'b1;
        end
      end
      SHIFT_LO: begin
        if (w_div_last) begin
          w_state_nxt = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (w_div_last) begin
          w_shift     = 1'b1;
          w_state_nxt = (r_bit_cnt == c_bit_last) ? LATCH : SHIFT_LO;
        end
      end
      LATCH: begin
        if (w_div_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_frame_nxt = r_frame;
    if (w_load) begin
      w_frame_nxt = w_frame_dec;
    end else if (w_shift) begin
      w_frame_nxt = {r_frame[SEG7_FRAME_W-2:0], 1'b0};
    end
  end

  // --------------------------------------------------------------------------
  // Divider, bit counter and frame register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_frame   <= '0;
    end else begin
      r_frame <= w_frame_nxt;

      // Every state change restarts the phase timer.
      if (w_state_nxt != r_state) begin
        r_div_cnt <= '0;
      end else if (w_timed) begin
        r_div_cnt <= r_div_cnt + 8'd1;
      end

      // Wraps 63 -> 0 naturally on the final shift.
      if (w_load) begin
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 6'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so that each output
  // lines up with the state it belongs to.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdata <= 1'b0;
      r_latch <= 1'b0;
      r_oe_n  <= 1'b1;
    end else begin
      r_busy  <= (w_state_nxt == SHIFT_LO) || (w_state_nxt == SHIFT_HI) ||
                 (w_state_nxt == LATCH);
      r_done  <= (w_state_nxt == DONE);
      r_sclk  <= (w_state_nxt == SHIFT_HI);
      r_latch <= (w_state_nxt == LATCH);

      // Data only moves while the shift clock is low, giving a full
      // half-period of setup before each rising edge.
      if (w_state_nxt == SHIFT_LO) begin
        r_sdata <= w_frame_nxt[SEG7_FRAME_W-1];
      end

      // Display stays enabled once a complete frame has been latched.
      if (w_state_nxt == DONE) begin
        r_oe_n <= 1'b0;
      end
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign sr_sclk_o  = r_sclk;
  assign sr_data_o  = r_sdata;
  assign sr_latch_o = r_latch;
  assign sr_oe_no   = r_oe_n;

endmodule : seg7_chain_driver
`default_nettype wire

// File: tb/tb_seg7_chain_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_chain_driver
// Purpose  : Self-checking bench for seg7_chain_driver. Two instances are
//            used (CLK_DIV=2 and CLK_DIV=1); the serial stream is rebuilt
//            from sr_sclk_o rising edges and compared with a frame computed
//            directly from the display rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_chain_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start;
  logic [31:0] data_i;
  logic [7:0]  dp_i;
  logic [1:0]  busy, done, sclk, sdat, lat, oen;
  logic [1:0]  oe_exp;

  int vec  = 0;
  int errs = 0;

  logic [7:0] lut [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  always #5 clk = ~clk;

  seg7_chain_driver #(.CLK_DIV(2), .NUM_DIGITS(8)) u_dut_div2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .data_i(data_i), .dp_i(dp_i),
    .busy_o(busy[0]), .done_o(done[0]), .sr_sclk_o(sclk[0]), .sr_data_o(sdat[0]),
    .sr_latch_o(lat[0]), .sr_oe_no(oen[0])
  );

  seg7_chain_driver #(.CLK_DIV(1), .NUM_DIGITS(8)) u_dut_div1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .data_i(data_i), .dp_i(dp_i),
    .busy_o(busy[1]), .done_o(done[1]), .sr_sclk_o(sclk[1]), .sr_data_o(sdat[1]),
    .sr_latch_o(lat[1]), .sr_oe_no(oen[1])
  );

  // Reference frame: byte k = {dp[k], segments of nibble k}, digit 7 at the top.
  function automatic logic [63:0] model_frame(input logic [31:0] d, input logic [7:0] p);
    logic [63:0] f;
    logic [7:0]  seg;
    f = '0;
    for (int k = 0; k < 8; k++) begin
      seg = lut[4'((d >> (4 * k)) & 32'hF)];
`ifdef SEG7_LZ_BLANK_EN
      if (k != 0 && (d >> (4 * k)) == 32'd0) seg = 8'h00;
`endif
      seg[7] = p[k];
      f = f | (64'(seg) << (8 * k));
    end
    return f;
  endfunction

  // mode 0: plain frame, 1: spurious starts + data change mid-frame,
  // 2: reset after 30 bits, 3: start held high for two back-to-back frames.
  task automatic run_frame(input int k, input logic [31:0] d, input logic [7:0] p, input int mode);
    logic [63:0] exp_f, got;
    int dv, t, rises, lat_cnt, n_done, n_exp, run_len, phase_err, hold_err, early_lat;
    int td [2];
    logic ps, pd, pb;
    bit stop;
    dv        = (k == 0) ? 2 : 1;
    n_exp     = (mode == 3) ? 2 : 1;
    exp_f     = model_frame(d, p);
    got       = '0;
    rises     = 0; lat_cnt = 0; n_done = 0; run_len = 0;
    phase_err = 0; hold_err = 0; early_lat = 0;
    td[0] = 0; td[1] = 0; t = 0; stop = 1'b0;
    @(negedge clk);
    data_i = d; dp_i = p; start[k] = 1'b1;
    ps = sclk[k]; pd = sdat[k]; pb = busy[k];
    @(posedge clk);  // accepting edge (end of cycle N)
    while (!stop) begin
      @(negedge clk);
      t++;
      if (t == 1) begin
        vec++;
        if (busy[k] !== 1'b1) begin
          errs++; $display("FAIL busy_at_N+1 dut%0d: got %b expected 1", k, busy[k]);
        end
        vec++;
        if (oen[k] !== oe_exp[k]) begin
          errs++; $display("FAIL oe_before_done dut%0d: got %b expected %b", k, oen[k], oe_exp[k]);
        end
        if (mode != 3) start[k] = 1'b0;
      end
      if (busy[k] === 1'b1 && pb !== 1'b1) run_len = 0;
      if (sclk[k] === ps) begin
        run_len++;
      end else begin
        if (run_len != dv) phase_err++;
        run_len = 1;
        if (sclk[k] === 1'b1) begin
          got = {got[62:0], sdat[k]};
          rises++;
        end
      end
      if (sdat[k] !== pd && !(ps === 1'b1 && sclk[k] === 1'b0) && pb === 1'b1) hold_err++;
      if (lat[k] === 1'b1) begin
        lat_cnt++;
        if (rises < 64 * (n_done + 1)) early_lat++;
      end
      if (done[k] === 1'b1) begin
        if (n_done < 2) td[n_done] = t;
        n_done++;
        vec++;
        if (busy[k] !== 1'b0) begin
          errs++; $display("FAIL busy_at_done dut%0d: got %b expected 0", k, busy[k]);
        end
      end
      if (mode == 1) begin
        if (t == 10 || t == 200) begin
          start[k] = 1'b1; data_i = ~d; dp_i = ~p;
        end
        if (t == 11 || t == 201) start[k] = 1'b0;
      end
      if (mode == 3 && n_done == 1 && t == td[0] + 2) begin
        vec++;
        if (busy[k] !== 1'b1) begin
          errs++; $display("FAIL restart_after_done dut%0d: busy got %b expected 1", k, busy[k]);
        end
        start[k] = 1'b0;
      end
      if (mode == 2 && rises == 30) begin
        rst_n = 1'b0;
        #1;
        vec++;
        if ({busy[k], done[k], sclk[k], sdat[k], lat[k], oen[k]} !== 6'b000001) begin
          errs++;
          $display("FAIL async_reset dut%0d: {busy,done,sclk,data,latch,oe_n} got %b expected 000001",
                   k, {busy[k], done[k], sclk[k], sdat[k], lat[k], oen[k]});
        end
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          vec++;
          if (lat[k] !== 1'b0 || done[k] !== 1'b0 || busy[k] !== 1'b0) begin
            errs++;
            $display("FAIL held_in_reset dut%0d: latch/done/busy got %b%b%b expected 000",
                     k, lat[k], done[k], busy[k]);
          end
        end
        rst_n  = 1'b1;
        oe_exp = 2'b11;
        return;
      end
      stop = (n_done >= n_exp && t >= td[n_exp - 1] + 3 && (mode != 1 || t >= 600)) || (t > 1500);
      ps = sclk[k]; pd = sdat[k]; pb = busy[k];
    end
    vec++;
    if (n_done !== n_exp) begin
      errs++; $display("FAIL done_count dut%0d: got %0d expected %0d", k, n_done, n_exp);
    end
    vec++;
    if (td[0] !== 129 * dv + 1) begin
      errs++; $display("FAIL done_cycle dut%0d: got N+%0d expected N+%0d", k, td[0], 129 * dv + 1);
    end
    if (mode == 3) begin
      vec++;
      if (td[1] !== td[0] + 129 * dv + 2) begin
        errs++; $display("FAIL second_done_cycle dut%0d: got N+%0d expected N+%0d", k, td[1], td[0] + 129 * dv + 2);
      end
    end
    vec++;
    if (rises !== 64 * n_exp) begin
      errs++; $display("FAIL sclk_rises dut%0d: got %0d expected %0d", k, rises, 64 * n_exp);
    end
    vec++;
    if (got !== exp_f) begin
      errs++; $display("FAIL frame dut%0d: got %h expected %h", k, got, exp_f);
    end
    vec++;
    if (phase_err != 0) begin
      errs++; $display("FAIL sclk_phase_len dut%0d: got %0d bad phases expected 0", k, phase_err);
    end
    vec++;
    if (hold_err != 0) begin
      errs++; $display("FAIL data_change_off_fall dut%0d: got %0d expected 0", k, hold_err);
    end
    vec++;
    if (lat_cnt !== dv * n_exp) begin
      errs++; $display("FAIL latch_width dut%0d: got %0d expected %0d", k, lat_cnt, dv * n_exp);
    end
    vec++;
    if (early_lat != 0) begin
      errs++; $display("FAIL latch_before_64_bits dut%0d: got %0d expected 0", k, early_lat);
    end
    vec++;
    if (oen[k] !== 1'b0) begin
      errs++; $display("FAIL oe_after_done dut%0d: got %b expected 0", k, oen[k]);
    end
    oe_exp[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 2'b00; data_i = '0; dp_i = '0; oe_exp = 2'b11;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vec++;
      if ({busy[k], done[k], sclk[k], sdat[k], lat[k], oen[k]} !== 6'b000001) begin
        errs++;
        $display("FAIL reset_values dut%0d: {busy,done,sclk,data,latch,oe_n} got %b expected 000001",
                 k, {busy[k], done[k], sclk[k], sdat[k], lat[k], oen[k]});
      end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vec++;
      if (busy[k] !== 1'b0 || oen[k] !== 1'b1 || sclk[k] !== 1'b0) begin
        errs++;
        $display("FAIL idle_after_reset dut%0d: busy/oe_n/sclk got %b%b%b expected 010",
                 k, busy[k], oen[k], sclk[k]);
      end
    end
  endtask

  task automatic test_decode_div2();
    run_frame(0, 32'h0123_4567, 8'h00, 0);
  endtask

  task automatic test_decode_div1_dp();
    run_frame(1, 32'h89AB_CDEF, 8'h81, 0);
  endtask

  task automatic test_ignore_start();
    run_frame(0, $urandom, 8'($urandom), 1);
  endtask

  task automatic test_reset_midframe();
    run_frame(0, $urandom, 8'($urandom), 2);
    run_frame(0, $urandom, 8'($urandom), 0);
  endtask

  task automatic test_leading_zero();
    run_frame(1, 32'h0000_0A05, 8'h00, 0);
    run_frame(0, 32'h0000_0000, 8'h00, 0);
  endtask

  task automatic test_back_to_back();
    run_frame(1, $urandom, 8'($urandom), 3);
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      if ($urandom_range(0, 2) == 0) d = d >> (4 * $urandom_range(1, 7));
      run_frame(int'($urandom_range(0, 1)), d, 8'($urandom), 0);
    end
  endtask

  initial begin
    test_reset();
    test_decode_div2();
    test_decode_div1_dp();
    test_ignore_start();
    test_reset_midframe();
    test_leading_zero();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule : tb_seg7_chain_driver
`default_nettype wire
